csr_stable_timer: RTL

//  Parametrised LoongArch timer unit owning CSRs TID, TCFG, TVAL, TICLR plus the free-running stable counter.

---
 rtl/csr_stable_timer_pkg.sv | 15 +
 rtl/csr_stable_timer_prescaler.sv | 20 ++
 rtl/csr_stable_timer.sv | 73 +++++++
 3 files changed

// File: rtl/csr_stable_timer_pkg.sv
// csr_stable_timer_pkg: CSR numbers, TCFG field indices and write masks for the timer unit
package csr_stable_timer_pkg;
  localparam logic [13:0] CSR_TID   = 14'h040;
  localparam logic [13:0] CSR_TCFG  = 14'h041;
  localparam logic [13:0] CSR_TVAL  = 14'h042;
  localparam logic [13:0] CSR_TICLR = 14'h044;
  localparam int DEF_TIMESIZE = 12;
  localparam int TCFG_EN = 0;
  localparam int TCFG_PERIODIC = 1;
  localparam logic [31:0] TID_WM = 32'hFFFF_FFFF;
  function automatic logic [31:0] tcfg_wm(input int timesize);
    return (32'h1 << (timesize + 2)) - 32'h1;
  endfunction
  localparam logic [31:0] TCFG_WM = tcfg_wm(DEF_TIMESIZE);
endpackage

// File: rtl/csr_stable_timer_prescaler.sv
// csr_stable_timer_prescaler: divides the core clock into one-cycle timer ticks while enabled
module csr_stable_timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic aclk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pcnt;
  logic at_top;
  assign at_top = pcnt == PW'(PRESCALE - 1);
  assign tick = en & at_top;
  // count holds while disabled; a restart request zeroes it so the next tick is a full period away
  always_ff @(posedge aclk)
    if (reset || clr) pcnt <= '0;
    else if (en) pcnt <= at_top ? '0 : pcnt + 1'b1;
endmodule

// File: rtl/csr_stable_timer.sv
// csr_stable_timer: TID/TCFG/TVAL/TICLR CSRs, countdown timer interrupt and free-running stable counter
module csr_stable_timer #(
  parameter int          TIMESIZE  = 12,
  parameter int          PRESCALE  = 1,
  parameter int          CNT_WIDTH = 64,
  parameter logic [31:0] CORE_ID   = 32'h0
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        csr_we,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] csr_wmask,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        csr_hit,
  output logic        timer_int,
  output logic [63:0] stable_cnt,
  output logic [31:0] tid
);
  import csr_stable_timer_pkg::*;
  localparam int TW = TIMESIZE + 2;
  localparam logic [31:0] WM_TCFG = tcfg_wm(TIMESIZE);
  logic [TW-1:0] tcfg, tcfg_new, tcfg_nx;
  logic [TIMESIZE-1:0] tval, tval_nx;
  logic ti, ti_nx;
  logic [CNT_WIDTH-1:0] cnt;
  logic [31:0] tcfg_m, tid_m;
  logic wr_tid, wr_tcfg, ticlr_clr, tick, fire, expire;
  assign wr_tid = csr_we && csr_waddr == CSR_TID;
  assign wr_tcfg = csr_we && csr_waddr == CSR_TCFG;
  assign ticlr_clr = csr_we && csr_waddr == CSR_TICLR && (csr_wdata[0] & csr_wmask[0]);
  assign tcfg_m = csr_wmask & WM_TCFG;
  assign tid_m = csr_wmask & TID_WM;
  assign tcfg_new = TW'((32'(tcfg) & ~tcfg_m) | (csr_wdata & tcfg_m));
  csr_stable_timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .aclk (aclk),
    .reset(reset),
    .en   (tcfg[TCFG_EN]),
    .clr  (wr_tcfg),
    .tick (tick)
  );
  assign fire = tick & tcfg[TCFG_EN] & ~wr_tcfg;
  assign expire = fire & (tval == '0);
  // a TCFG write reloads and suppresses that cycle's countdown; a one-shot timeout drops En itself
  always_comb begin
    tval_nx = wr_tcfg ? tcfg_new[TW-1:2] : !fire ? tval : !expire ? tval - 1'b1 : tcfg[TCFG_PERIODIC] ? tcfg[TW-1:2] : '1;
    tcfg_nx = wr_tcfg ? tcfg_new : (expire & ~tcfg[TCFG_PERIODIC]) ? {tcfg[TW-1:1], 1'b0} : tcfg;
    ti_nx = expire | (ti & ~ticlr_clr);
  end
  // timer state and the stable counter, which runs every cycle regardless of CSR traffic
  always_ff @(posedge aclk)
    if (reset) begin
      tcfg <= '0;
      tval <= '0;
      ti <= 1'b0;
      tid <= CORE_ID;
      cnt <= '0;
    end else begin
      tcfg <= tcfg_nx;
      tval <= tval_nx;
      ti <= ti_nx;
      tid <= wr_tid ? (tid & ~tid_m) | (csr_wdata & tid_m) : tid;
      cnt <= cnt + 1'b1;
    end
  // combinational read port; TICLR always reads zero
  always_comb begin
    csr_hit = csr_raddr == CSR_TID || csr_raddr == CSR_TCFG || csr_raddr == CSR_TVAL || csr_raddr == CSR_TICLR;
    csr_rdata = csr_raddr == CSR_TID ? tid : csr_raddr == CSR_TCFG ? 32'(tcfg) : csr_raddr == CSR_TVAL ? 32'(tval) : 32'h0;
  end
  assign timer_int = ti;
  assign stable_cnt = 64'(cnt);
endmodule
